// File: rtl/secuenciador_multiciclo_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state codes,
// opcodes, PC source selects and the registered control word.
package secuenciador_pkg;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_MEM  = 4'd1,
        DECODE     = 4'd2,
        EXEC_ALU   = 4'd3,
        MEM_ADDR   = 4'd4,
        MEM_ACCESS = 4'd5,
        WB         = 4'd6,
        EXEC_BR    = 4'd7,
        HALT       = 4'd8,
        ERROR      = 4'd9
    } estado_t;

    localparam logic [6:0] OP_NOP   = 7'h00;
    localparam logic [6:0] OP_LOAD  = 7'h10;
    localparam logic [6:0] OP_STORE = 7'h11;
    localparam logic [6:0] OP_JMP   = 7'h12;
    localparam logic [6:0] OP_BZ    = 7'h13;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       select_ar;
        logic       load_ar;
        logic [1:0] select_pc;
        logic       load_pc;
        logic       load_cr;
        logic       write_select;
        logic       write_enable;
        logic [3:0] fun;
        logic       detenido;
        logic       error;
    } ctrl_t;

    // Moore control word of a state; the opcode only matters for Fun and MemWe.
    function automatic ctrl_t decodificar(estado_t s, logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:      c.load_ar = 1'b1;
            FETCH_MEM:  c.mem_req = 1'b1;
            EXEC_ALU: begin
                c.fun          = op[3:0];
                c.write_enable = 1'b1;
                c.load_cr      = 1'b1;
            end
            MEM_ADDR: begin
                c.select_ar = 1'b1;
                c.load_ar   = 1'b1;
            end
            MEM_ACCESS: begin
                c.mem_req = 1'b1;
                c.mem_we  = (op == OP_STORE);
            end
            WB: begin
                c.write_select = 1'b1;
                c.write_enable = 1'b1;
            end
            EXEC_BR: begin
                c.select_pc = PC_REG;
                c.load_pc   = 1'b1;
            end
            HALT:       c.detenido = 1'b1;
            ERROR:      c.error    = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/secuenciador_multiciclo_if.sv
// Memory request/acknowledge handshake between the sequencer and the
// single-port memory.
interface secuenciador_multiciclo_if;
    logic MemReq;
    logic MemWe;
    logic MemAck;

    modport master (output MemReq, output MemWe, input MemAck);
    modport slave  (input MemReq, input MemWe, output MemAck);
endinterface

// File: rtl/secuenciador_multiciclo_contador_espera.sv
// Memory wait counter: counts cycles a request has been left unanswered and
// flags when the next unanswered cycle would reach WAIT_MAX.
module contador_espera #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expirado_o
);
    localparam logic [7:0] LIMITE = 8'(WAIT_MAX - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expirado_o = (cnt_q >= LIMITE);

endmodule

// File: rtl/secuenciador_multiciclo.sv
// Fetch/decode/execute sequencer driving the 16-bit datapath strobes and the
// memory handshake.
module secuenciador_multiciclo
    import secuenciador_pkg::*;
#(
    parameter int         WAIT_MAX = 15,
    parameter logic [6:0] OPC_HALT = 7'h7F
) (
    input  logic                      Reloj,
    input  logic                      Reiniciar,
    input  logic [15:0]               Instruccion,
    input  logic                      CeroCR,
    secuenciador_multiciclo_if.master mem,
    output logic                      SelectDR,
    output logic                      LoadDR,
    output logic                      SelectAR,
    output logic                      LoadAR,
    output logic [1:0]                SelectPC,
    output logic                      LoadPC,
    output logic                      LoadIR,
    output logic                      LoadCR,
    output logic                      WriteSelect,
    output logic                      WriteEnable,
    output logic [2:0]                WriteAddress,
    output logic [2:0]                ReadAddressA,
    output logic [2:0]                ReadAddressB,
    output logic [3:0]                Fun,
    output logic [3:0]                Estado,
    output logic                      Detenido,
    output logic                      Error
);
    logic [6:0] opcode;
    estado_t    estado_q;
    estado_t    estado_d;
    ctrl_t      ctrl_q;
    logic       en_acceso;
    logic       expirado;
    logic       ack_fetch;
    logic       ack_acceso;

    assign opcode    = Instruccion[15:9];
    assign en_acceso = (estado_q == FETCH_MEM) || (estado_q == MEM_ACCESS);

    contador_espera #(.WAIT_MAX(WAIT_MAX)) u_espera (
        .clk_i      (Reloj),
        .rst_ni     (Reiniciar),
        .clr_i      (!en_acceso),
        .en_i       (en_acceso && !mem.MemAck),
        .expirado_o (expirado)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            FETCH:     estado_d = FETCH_MEM;
            FETCH_MEM: begin
                if (mem.MemAck)    estado_d = DECODE;
                else if (expirado) estado_d = ERROR;
            end
            DECODE: begin
                if (opcode == OPC_HALT)                      estado_d = HALT;
                else if (opcode == OP_NOP)                   estado_d = FETCH;
                else if (opcode inside {[7'h01:7'h0F]})      estado_d = EXEC_ALU;
                else if (opcode inside {OP_LOAD, OP_STORE})  estado_d = MEM_ADDR;
                else if (opcode == OP_JMP)                   estado_d = EXEC_BR;
                else if (opcode == OP_BZ)                    estado_d = CeroCR ? EXEC_BR : FETCH;
                else                                         estado_d = FETCH;
            end
            MEM_ADDR:   estado_d = MEM_ACCESS;
            MEM_ACCESS: begin
                if (mem.MemAck)    estado_d = (opcode == OP_LOAD) ? WB : FETCH;
                else if (expirado) estado_d = ERROR;
            end
            EXEC_ALU, WB, EXEC_BR: estado_d = FETCH;
            HALT:       estado_d = HALT;
            ERROR:      estado_d = ERROR;
            default:    estado_d = FETCH;
        endcase
    end

    // Control word is registered from the next state so it lines up with
    // estado_q; reset clears it, so the first FETCH after reset has no strobes.
    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            estado_q <= FETCH;
            ctrl_q   <= '0;
        end else begin
            estado_q <= estado_d;
            ctrl_q   <= decodificar(estado_d, opcode);
        end
    end

    // Only these strobes react to MemAck within the cycle it arrives.
    assign ack_fetch  = (estado_q == FETCH_MEM) && mem.MemAck;
    assign ack_acceso = (estado_q == MEM_ACCESS) && mem.MemAck && (opcode == OP_LOAD);

    assign mem.MemReq   = ctrl_q.mem_req;
    assign mem.MemWe    = ctrl_q.mem_we;
    assign LoadIR       = ack_fetch;
    assign LoadPC       = ctrl_q.load_pc | ack_fetch;
    assign SelectPC     = ack_fetch ? PC_INC : ctrl_q.select_pc;
    assign SelectDR     = ack_acceso;
    assign LoadDR       = ack_acceso;
    assign SelectAR     = ctrl_q.select_ar;
    assign LoadAR       = ctrl_q.load_ar;
    assign LoadCR       = ctrl_q.load_cr;
    assign WriteSelect  = ctrl_q.write_select;
    assign WriteEnable  = ctrl_q.write_enable;
    assign Fun          = ctrl_q.fun;
    assign Detenido     = ctrl_q.detenido;
    assign Error        = ctrl_q.error;
    assign Estado       = estado_q;
    assign WriteAddress = Instruccion[8:6];
    assign ReadAddressA = Instruccion[5:3];
    assign ReadAddressB = Instruccion[2:0];

endmodule

// File: tb/tb_secuenciador_multiciclo.sv
// Directed bench for secuenciador_multiciclo: cycle-by-cycle vector table
// plus hand-written reset, timeout and halt sequences.
module tb_secuenciador_multiciclo;

    logic        Reloj = 1'b0;
    logic        Reiniciar = 1'b0;
    logic [15:0] Instruccion = 16'h0000;
    logic        CeroCR = 1'b0;
    logic        SelectDR, LoadDR, SelectAR, LoadAR, LoadPC, LoadIR, LoadCR;
    logic        WriteSelect, WriteEnable, Detenido, Error;
    logic [1:0]  SelectPC;
    logic [2:0]  WriteAddress, ReadAddressA, ReadAddressB;
    logic [3:0]  Fun, Estado;

    secuenciador_multiciclo_if mem_bus();

    secuenciador_multiciclo #(.WAIT_MAX(15), .OPC_HALT(7'h7F)) dut (
        .Reloj(Reloj), .Reiniciar(Reiniciar), .Instruccion(Instruccion), .CeroCR(CeroCR),
        .mem(mem_bus.master),
        .SelectDR(SelectDR), .LoadDR(LoadDR), .SelectAR(SelectAR), .LoadAR(LoadAR),
        .SelectPC(SelectPC), .LoadPC(LoadPC), .LoadIR(LoadIR), .LoadCR(LoadCR),
        .WriteSelect(WriteSelect), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
        .ReadAddressA(ReadAddressA), .ReadAddressB(ReadAddressB), .Fun(Fun),
        .Estado(Estado), .Detenido(Detenido), .Error(Error)
    );

    always #5 Reloj = ~Reloj;

    localparam logic [3:0] S_FE = 4'd0, S_FM = 4'd1, S_DE = 4'd2, S_AL = 4'd3, S_MA = 4'd4;
    localparam logic [3:0] S_MX = 4'd5, S_WB = 4'd6, S_BR = 4'd7, S_HA = 4'd8, S_ER = 4'd9;

    localparam logic [14:0] MREQ = 15'd1,    MWE = 15'd2,    SDR = 15'd4,    LDR = 15'd8;
    localparam logic [14:0] SAR  = 15'd16,   LAR = 15'd32,   PCI = 15'd64,   PCR = 15'd128;
    localparam logic [14:0] LPC  = 15'd256,  LIR = 15'd512,  LCR = 15'd1024, WSEL = 15'd2048;
    localparam logic [14:0] WEN  = 15'd4096, DET = 15'd8192, ERR = 15'd16384;
    localparam logic [14:0] FT   = MREQ | LIR | LPC | PCI;
    localparam logic [14:0] NONE = 15'd0;

    logic [14:0] str_act;
    assign str_act = {Error, Detenido, WriteEnable, WriteSelect, LoadCR, LoadIR, LoadPC,
                      SelectPC, LoadAR, SelectAR, LoadDR, SelectDR, mem_bus.MemWe, mem_bus.MemReq};

    typedef struct {
        logic [15:0] ins;
        logic        cero;
        logic        ack;
        logic [3:0]  est;
        logic [14:0] str;
        logic [3:0]  fun;
    } fila_t;

    fila_t tabla[$];
    int total = 0;
    int bad = 0;

    task automatic add(input logic [15:0] ins, input logic c, input logic a,
                       input logic [3:0] est, input logic [14:0] str, input logic [3:0] fun);
        fila_t f;
        f.ins = ins; f.cero = c; f.ack = a; f.est = est; f.str = str; f.fun = fun;
        tabla.push_back(f);
    endtask

    // Drives one cycle's inputs just after the rising edge, checks at the falling edge.
    task automatic ciclo(input string nm, input logic [15:0] ins, input logic c, input logic a,
                         input logic [3:0] e_est, input logic [14:0] e_str, input logic [3:0] e_fun);
        Instruccion = ins;
        CeroCR = c;
        mem_bus.MemAck = a;
        @(negedge Reloj);
        total++;
        if (Estado !== e_est || str_act !== e_str || Fun !== e_fun) begin
            bad++;
            $display("FAIL %s: got estado=%0d strobes=%h fun=%h, want estado=%0d strobes=%h fun=%h",
                     nm, Estado, str_act, Fun, e_est, e_str, e_fun);
        end
        @(posedge Reloj);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Leaves the DUT in the first FETCH_MEM cycle after a reset pulse.
    task automatic reset_dut();
        Reiniciar = 1'b0;
        mem_bus.MemAck = 1'b0;
        @(negedge Reloj);
        #2 Reiniciar = 1'b1;
        @(posedge Reloj);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        mem_bus.MemAck = 1'b0;

        // ALU 0611, immediate ack; ack during DECODE must be ignored
        add(16'h0611, 0, 1, S_FM, FT, 0);
        add(16'h0611, 0, 1, S_DE, NONE, 0);
        add(16'h0611, 0, 0, S_AL, WEN | LCR, 4'd3);
        // LOAD 2050: one fetch wait, ack delayed 3 cycles in MEM_ACCESS
        add(16'h2050, 0, 1, S_FE, LAR, 0);
        add(16'h2050, 0, 0, S_FM, MREQ, 0);
        add(16'h2050, 0, 1, S_FM, FT, 0);
        add(16'h2050, 0, 0, S_DE, NONE, 0);
        add(16'h2050, 0, 0, S_MA, SAR | LAR, 0);
        add(16'h2050, 0, 0, S_MX, MREQ, 0);
        add(16'h2050, 0, 0, S_MX, MREQ, 0);
        add(16'h2050, 0, 0, S_MX, MREQ, 0);
        add(16'h2050, 0, 1, S_MX, MREQ | SDR | LDR, 0);
        add(16'h2050, 0, 0, S_WB, WSEL | WEN, 0);
        // STORE 2213
        add(16'h2213, 0, 0, S_FE, LAR, 0);
        add(16'h2213, 0, 1, S_FM, FT, 0);
        add(16'h2213, 0, 0, S_DE, NONE, 0);
        add(16'h2213, 0, 0, S_MA, SAR | LAR, 0);
        add(16'h2213, 0, 1, S_MX, MREQ | MWE, 0);
        // BZ 2610 not taken, then taken
        add(16'h2610, 0, 0, S_FE, LAR, 0);
        add(16'h2610, 0, 1, S_FM, FT, 0);
        add(16'h2610, 0, 0, S_DE, NONE, 0);
        add(16'h2610, 1, 0, S_FE, LAR, 0);
        add(16'h2610, 1, 1, S_FM, FT, 0);
        add(16'h2610, 1, 0, S_DE, NONE, 0);
        add(16'h2610, 1, 0, S_BR, PCR | LPC, 0);
        // JMP 2400
        add(16'h2400, 0, 0, S_FE, LAR, 0);
        add(16'h2400, 0, 1, S_FM, FT, 0);
        add(16'h2400, 0, 0, S_DE, NONE, 0);
        add(16'h2400, 0, 0, S_BR, PCR | LPC, 0);
        // Undefined opcode 40 and NOP 0000 return straight to FETCH
        add(16'h8000, 0, 0, S_FE, LAR, 0);
        add(16'h8000, 0, 1, S_FM, FT, 0);
        add(16'h8000, 0, 0, S_DE, NONE, 0);
        add(16'h0000, 0, 0, S_FE, LAR, 0);
        add(16'h0000, 0, 1, S_FM, FT, 0);
        add(16'h0000, 0, 0, S_DE, NONE, 0);
        // ALU opcode 0F
        add(16'h1E3F, 0, 0, S_FE, LAR, 0);
        add(16'h1E3F, 0, 1, S_FM, FT, 0);
        add(16'h1E3F, 0, 0, S_DE, NONE, 0);
        add(16'h1E3F, 0, 0, S_AL, WEN | LCR, 4'hF);
        add(16'h1E3F, 0, 0, S_FE, LAR, 0);

        // Reset state and release between edges
        @(negedge Reloj);
        chk("reset_estado", 32'(Estado), 32'(S_FE));
        chk("reset_strobes", 32'({str_act, Fun}), 32'd0);
        #2 Reiniciar = 1'b1;
        #1;
        chk("release_strobes", 32'({Estado, str_act, Fun}), 32'd0);
        @(posedge Reloj);
        #1;

        for (int i = 0; i < tabla.size(); i++) begin
            ciclo($sformatf("row%0d", i), tabla[i].ins, tabla[i].cero, tabla[i].ack,
                  tabla[i].est, tabla[i].str, tabla[i].fun);
        end

        Instruccion = 16'h0611;
        #1;
        chk("addr_0611", 32'({WriteAddress, ReadAddressA, ReadAddressB}), 32'({3'd0, 3'd2, 3'd1}));
        Instruccion = 16'h2050;
        #1;
        chk("addr_2050", 32'({WriteAddress, ReadAddressA}), 32'({3'd1, 3'd2}));

        // Reset in the middle of a LOAD access
        reset_dut();
        ciclo("mr_fm", 16'h2050, 0, 1, S_FM, FT, 0);
        ciclo("mr_de", 16'h2050, 0, 0, S_DE, NONE, 0);
        ciclo("mr_ma", 16'h2050, 0, 0, S_MA, SAR | LAR, 0);
        ciclo("mr_mx", 16'h2050, 0, 0, S_MX, MREQ, 0);
        #2 Reiniciar = 1'b0;
        #1;
        chk("mr_memreq_drop", 32'(mem_bus.MemReq), 32'd0);
        chk("mr_in_reset", 32'({Estado, str_act, Fun}), 32'd0);
        @(negedge Reloj);
        #2 Reiniciar = 1'b1;
        #1;
        chk("mr_after_release", 32'({Estado, str_act, Fun}), 32'd0);
        @(posedge Reloj);
        #1;

        // Fetch timeout: 15 unanswered cycles, then sticky ERROR
        for (int k = 1; k <= 15; k++) begin
            ciclo($sformatf("to_wait%0d", k), 16'h0000, 0, 0, S_FM, MREQ, 0);
        end
        for (int k = 0; k < 6; k++) begin
            ciclo($sformatf("to_err%0d", k), 16'h0000, 0, 1'(k), S_ER, ERR, 0);
        end

        // Ack on the 15th cycle completes normally
        reset_dut();
        for (int k = 1; k <= 14; k++) begin
            ciclo($sformatf("late_wait%0d", k), 16'h0000, 0, 0, S_FM, MREQ, 0);
        end
        ciclo("late_ack", 16'h0000, 0, 1, S_FM, FT, 0);
        ciclo("late_de", 16'h0000, 0, 0, S_DE, NONE, 0);
        ciclo("late_fe", 16'h0000, 0, 0, S_FE, LAR, 0);

        // HALT holds with no strobes until reset
        reset_dut();
        ciclo("halt_fm", 16'hFE00, 0, 1, S_FM, FT, 0);
        ciclo("halt_de", 16'hFE00, 0, 0, S_DE, NONE, 0);
        for (int k = 0; k < 22; k++) begin
            ciclo($sformatf("halt%0d", k), 16'hFE00, 1'(k >> 1), 1'(k), S_HA, DET, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
